fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the 5-stage core, directly upstream of the hazard unit.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 29 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch FSM encodings and NOP constant
package fetch_stage_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;
    localparam fetch_state_t S_DROP = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry holding register for a response caught during StallF
module fetch_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic [31:0] data,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload needs no reset: it is only consumed while valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= data_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with single-outstanding imem fetch and IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        fetch_wait
);

    fetch_state_t state, state_next;
    logic [31:0]  pcf, pcf_next;
    logic [31:0]  target;
    logic [31:0]  buf_data, deliver_word;
    logic         buf_valid, buf_load, buf_clear;
    logic         deliver, accept;

    assign target         = {PCTargetE[31:2], 2'b00};
    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_addr      = pcf;
    assign accept         = imem_req_valid && imem_req_ready;
    assign fetch_wait     = !((state == S_HOLD) || ((state == S_WAIT) && imem_rsp_valid));

    fetch_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .clear   (buf_clear),
        .data_in (imem_rsp_data),
        .data    (buf_data),
        .valid   (buf_valid)
    );

    // A redirect always wins over advancing; an in-flight response becomes stale.
    always_comb begin
        state_next   = state;
        pcf_next     = pcf;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        deliver      = 1'b0;
        deliver_word = imem_rsp_data;
        case (state)
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_next = target;
                    if (accept) state_next = S_DROP;
                end else if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pcf_next   = target;
                    state_next = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (!StallF) begin
                        deliver    = 1'b1;
                        pcf_next   = pcf + 32'd4;
                        state_next = S_REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                deliver_word = buf_data;
                if (PCSrcE) begin
                    pcf_next   = target;
                    buf_clear  = 1'b1;
                    state_next = S_REQ;
                end else if (!StallF && buf_valid) begin
                    deliver    = 1'b1;
                    pcf_next   = pcf + 32'd4;
                    buf_clear  = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (PCSrcE) pcf_next = target;
                if (imem_rsp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
            pcf   <= RESET_ADDR;
        end else begin
            state <= state_next;
            pcf   <= pcf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
        end else if (deliver) begin
            InstrD   <= deliver_word;
            PCD      <= pcf;
            PCPlus4D <= pcf + 32'd4;
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end
    end

endmodule
